// File: rtl/truth_table_sequencer.sv
// ---------------------------------------------------------------------------
// truth_table_sequencer
//
// Sweeps every input vector of a small combinational unit and records its
// truth table. Each vector k (0 .. 2^N_IN-1) is driven on dut_in for SETTLE
// cycles and then held for one more cycle while dut_out is captured into
// table_out[k]. When the sweep ends, the captured table is compared with the
// expected table that was latched at start. The block then reports pass and
// the number of mismatching bit positions.
//
// Parameters
//   N_IN    number of unit inputs (1..4)
//   SETTLE  cycles each vector is held before it is sampled (>= 1)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       request one full sweep (accepted only in IDLE)
//   expected    expected truth table, bit k = unit output for vector k
//   dut_in      vector driven to the unit, 0 outside a sweep
//   dut_out     unit output, sampled by this block
//   busy        high while vectors are being driven or sampled
//   done        one-cycle pulse at the end of a sweep
//   table_out   captured truth table
//   pass        table_out matches the latched expected table
//   fail_count  number of mismatching bit positions
// ---------------------------------------------------------------------------
module truth_table_sequencer #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [(1<<N_IN)-1:0] expected,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic [(1<<N_IN)-1:0] table_out,
  output logic                 pass,
  output logic [N_IN:0]        fail_count
);

  localparam int NV = 1 << N_IN;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  // The settle counter counts down from SETTLE-1 and leaves DRIVE at zero.
  localparam logic [SW-1:0]   SETTLE_RELOAD = SW'(SETTLE - 1);
  localparam logic [N_IN-1:0] K_LAST        = N_IN'(NV - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [N_IN-1:0] k_q, k_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [NV-1:0]   exp_q, exp_d;
  logic [NV-1:0]   table_q, table_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   fail_q, fail_d;

  logic last_vec;
  assign last_vec = (k_q == K_LAST);

  function automatic logic [N_IN:0] popcount(input logic [NV-1:0] v);
    logic [N_IN:0] c;
    c = '0;
    for (int i = 0; i < NV; i++) begin
      c = c + {{N_IN{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // -------------------------------------------------------------------------
  // State register and datapath flops
  // -------------------------------------------------------------------------
  // NOTE: the latched expected table is reset along with everything else.
  // It is wide, but a reset sweep must never compare against stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      settle_q <= '0;
      exp_q    <= '0;
      table_q  <= '0;
      pass_q   <= 1'b0;
      fail_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop update from the same
      // pre-edge values, independent of statement order.
      state_q  <= state_d;
      k_q      <= k_d;
      settle_q <= settle_d;
      exp_q    <= exp_d;
      table_q  <= table_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: the default assignment first means every path assigns state_d,
    // so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   if (settle_q == '0) state_d = SAMPLE;
      SAMPLE:  state_d = last_vec ? DONE : DRIVE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: vector index, settle counter, captured table and verdict
  // -------------------------------------------------------------------------
  always_comb begin
    k_d      = k_q;
    settle_d = settle_q;
    exp_d    = exp_q;
    table_d  = table_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          exp_d    = expected;
          table_d  = '0;
          pass_d   = 1'b0;
          fail_d   = '0;
          k_d      = '0;
          settle_d = SETTLE_RELOAD;
        end
      end
      DRIVE: begin
        if (settle_q != '0) settle_d = settle_q - SW'(1);
      end
      SAMPLE: begin
        table_d[k_q] = dut_out;
        if (last_vec) begin
          // The verdict is computed from the completed table, including the
          // bit captured at this edge. It is registered on entry to DONE, so
          // it is already valid during the done pulse.
          pass_d = (table_d == exp_q);
          fail_d = popcount(table_d ^ exp_q);
        end else begin
          k_d      = k_q + N_IN'(1);
          settle_d = SETTLE_RELOAD;
        end
      end
      DONE:    ;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    busy   = (state_q == DRIVE) || (state_q == SAMPLE);
    done   = (state_q == DONE);
    dut_in = ((state_q == DRIVE) || (state_q == SAMPLE)) ? k_q : '0;
  end

  assign table_out  = table_q;
  assign pass       = pass_q;
  assign fail_count = fail_q;

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 SHALL provide parameters, one per line:
  N_IN   2   number of inputs of the combinational unit under control (legal 1..4)
  SETTLE 1   cycles each input vector is held before sampling (legal >= 1)
REQ-002 SHALL provide ports, one per line:
  clk        input   1          single clock; all state updates on its rising edge
  rst_n      input   1          reset, asynchronous, active-low
  start      input   1          request one full sweep of all 2^N_IN input vectors
  expected   input   2^N_IN     expected truth table; bit k is the output for vector k
  dut_in     output  N_IN       vector driven to the combinational unit ({a,b} for N_IN=2, a=MSB)
  dut_out    input   1          combinational unit output, sampled by this block
  busy       output  1          sweep in progress
  done       output  1          one-cycle pulse at the end of a sweep
  table_out  output  2^N_IN     captured truth table; bit k = dut_out sampled for vector k
  pass       output  1          table_out == latched expected, valid from done onward
  fail_count output  N_IN+1     number of bit positions where table_out differs from expected
REQ-003 SHALL use one clock, clk; reset rst_n is asynchronous and active-low.

Function
REQ-004 SHALL implement the FSM states IDLE, DRIVE, SAMPLE, DONE; the reset state is IDLE.
REQ-005 IDLE: start=1 sampled at a clock edge SHALL latch expected, clear table_out, pass and fail_count, set vector index k=0, and move to DRIVE.
REQ-006 DRIVE: dut_in=k for exactly SETTLE cycles, then move to SAMPLE.
REQ-007 SAMPLE (one cycle, dut_in still =k): table_out[k] <= dut_out; if k=2^N_IN-1 move to DONE, else k <= k+1 and return to DRIVE.
REQ-008 DONE (one cycle): done=1; pass and fail_count SHALL be registered from table_out vs latched expected; next state IDLE.
REQ-009 busy=1 exactly in DRIVE and SAMPLE; done=1 exactly in DONE; never both high.
REQ-010 Latency: start accepted at edge 0 -> vector k in DRIVE from cycle 1+k(SETTLE+1); DONE in cycle 2^N_IN*(SETTLE+1)+1 (cycle 9 for defaults).
REQ-011 start SHALL be ignored in DRIVE, SAMPLE and DONE; changes on expected after acceptance SHALL have no effect.
REQ-012 start held high continuously SHALL begin a new sweep at the edge after DONE returns to IDLE; table_out, pass and fail_count clear at that acceptance.
REQ-013 Outside a sweep, dut_in SHALL hold 0.
REQ-014 table_out, pass and fail_count SHALL hold their values from DONE until the next accepted start.
REQ-015 k SHALL be N_IN bits wide and SHALL never wrap past 2^N_IN-1 within a sweep; fail_count SHALL be a popcount of (table_out XOR expected), max 2^N_IN.
REQ-016 Settle counter SHALL be sized for SETTLE and reload on every entry to DRIVE.

Reset
REQ-017 rst_n=0 SHALL immediately, without a clock edge, force state=IDLE, busy=0, done=0, dut_in=0, table_out=0, pass=0, fail_count=0, k=0, and clear the latched expected.
REQ-018 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; the first start after release SHALL run a full sweep from k=0.

Verification
REQ-019 Defaults, unit y=a&b, expected=4'b1000, start pulsed at cycle 0 -> dut_in steps 0,1,2,3 two cycles each, done at cycle 9, table_out=4'b1000, pass=1, fail_count=0.
REQ-020 Same unit, expected=4'b0110 -> table_out=4'b1000, pass=0, fail_count=3.
REQ-021 start re-pulsed at cycles 3 and 9, expected changed at cycle 4 -> both ignored, single done at cycle 9, result uses the expected latched at cycle 0.
REQ-022 start held high from cycle 0 -> done at cycles 9 and 19, table_out cleared at the second acceptance (cycle 10), busy high from cycle 11.
REQ-023 rst_n low for one cycle at cycle 5 of a sweep -> all outputs 0 asynchronously, no done; next start -> full 9-cycle sweep with correct result.
REQ-024 SETTLE=3, N_IN=3, unit y=parity, expected=8'b10010110 -> done at cycle 33, pass=1.
